// File: rtl/layer_scheduler.sv
// Time-multiplexed dense layer: NUM_NODES neurons share one 8x8 MAC, weights and
// biases streamed from an external synchronous ROM, ReLU applied on emit.
module layer_scheduler #(
  parameter int NUM_IN    = 15,
  parameter int NUM_NODES = 16,
  parameter int AW        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_IN*8-1:0]   in_data,
  output logic [AW-1:0]         w_addr,
  input  logic [7:0]            w_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_node,
  output logic [15:0]           out_data,
  output logic                  done
);

  localparam int KW = $clog2(NUM_IN + 2);
  localparam logic [KW-1:0] K_BIAS    = KW'(NUM_IN);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_IN + 1);
  localparam logic [3:0]    NODE_LAST = 4'(NUM_NODES - 1);

  typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;

  state_t                state, state_nxt;
  logic [NUM_IN*8-1:0]   act;
  logic [3:0]            node;
  logic [KW-1:0]         k;
  logic [KW-1:0]         j;
  logic signed [15:0]    acc;
  logic signed [7:0]     a_sel;
  logic signed [7:0]     w_s;
  logic signed [15:0]    prod;
  logic signed [15:0]    term;

  function automatic logic [15:0] relu(input logic signed [15:0] v);
    return v[15] ? 16'd0 : v;
  endfunction

  // k counts RUN cycles; ROM data seen in cycle k belongs to address slot k-1
  assign j   = k - KW'(1);
  assign w_s = signed'(w_data);

  always_comb begin
    a_sel = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (j == KW'(i)) a_sel = act[i*8 +: 8];
  end

  assign prod = 16'(a_sel) * 16'(w_s);
  assign term = (j == K_BIAS) ? 16'(w_s) : prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (k == K_LAST) state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = (node == NODE_LAST) ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset && (state == IDLE);
    out_valid = (state == EMIT);
    out_node  = node;
    out_data  = out_valid ? relu(acc) : 16'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act    <= '0;
      node   <= '0;
      k      <= '0;
      acc    <= '0;
      w_addr <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            act    <= in_data;
            node   <= '0;
            k      <= '0;
            acc    <= '0;
            w_addr <= '0;
          end
        end
        RUN: begin
          k <= k + KW'(1);
          if (k < K_BIAS) w_addr <= w_addr + AW'(1);
          if (k != '0)    acc    <= acc + term;
        end
        EMIT: begin
          if (out_ready) begin
            if (node == NODE_LAST) begin
              done <= 1'b1;
            end else begin
              // next node's weights start right after this node's bias
              node   <= node + 4'd1;
              k      <= '0;
              acc    <= '0;
              w_addr <= w_addr + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: ROM model plus a dot-product/ReLU reference per node.
module tb_layer_scheduler;

  localparam int NUM_IN    = 15;
  localparam int NUM_NODES = 16;
  localparam int AW        = 8;
  localparam int STRIDE    = NUM_IN + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_IN*8-1:0] in_data;
  logic [AW-1:0]       w_addr;
  logic [7:0]          w_data;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_node;
  logic [15:0]         out_data;
  logic                done;

  logic signed [7:0] rom [0:(1<<AW)-1];
  logic signed [7:0] av  [0:NUM_IN-1];

  int vectors     = 0;
  int miscompares = 0;

  layer_scheduler #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_node(out_node), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];

  function automatic logic [15:0] model(input int n);
    int s;
    logic [15:0] w;
    s = 0;
    for (int k = 0; k < NUM_IN; k++) s += int'(av[k]) * int'(rom[n*STRIDE + k]);
    s += int'(rom[n*STRIDE + NUM_IN]);
    w = s[15:0];
    return w[15] ? 16'd0 : w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input int wmode, input int bmode, input bit rnd);
    for (int n = 0; n < NUM_NODES; n++)
      for (int k = 0; k <= NUM_IN; k++)
        if (rnd)              rom[n*STRIDE + k] = 8'($urandom);
        else if (k < NUM_IN)  rom[n*STRIDE + k] = 8'(wmode);
        else                  rom[n*STRIDE + k] = 8'(bmode);
  endtask

  task automatic pack_act;
    for (int k = 0; k < NUM_IN; k++) in_data[k*8 +: 8] = av[k];
  endtask

  task automatic run_vector(input string name, input int stall_node, input int abort_node);
    int cnt;
    int bad;
    pack_act();
    check($sformatf("%s in_ready", name), in_ready, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < NUM_NODES; n++) begin
      check($sformatf("%s n%0d w_addr", name, n), w_addr, n*STRIDE);
      if (n == abort_node) begin
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check($sformatf("%s rst out_valid", name), out_valid, 0);
        check($sformatf("%s rst out_node", name), out_node, 0);
        check($sformatf("%s rst out_data", name), out_data, 0);
        check($sformatf("%s rst w_addr", name), w_addr, 0);
        check($sformatf("%s rst in_ready", name), in_ready, 0);
        check($sformatf("%s rst done", name), done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check($sformatf("%s post-rst in_ready", name), in_ready, 1);
        bad = 0;
        repeat (40) begin
          @(negedge clk);
          if (out_valid || done || !in_ready) bad++;
        end
        check($sformatf("%s stray after rst", name), bad, 0);
        return;
      end
      cnt = 0;
      while (!out_valid && cnt < 60) begin
        @(negedge clk);
        cnt++;
      end
      check($sformatf("%s n%0d latency", name, n), cnt, NUM_IN + 2);
      check($sformatf("%s n%0d out_node", name, n), out_node, n);
      check($sformatf("%s n%0d out_data", name, n), out_data, model(n));
      if (n == stall_node) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          in_valid = 1'b1;
          in_data  = {NUM_IN{8'($urandom)}};
          @(negedge clk);
          check($sformatf("%s stall%0d valid", name, s), out_valid, 1);
          check($sformatf("%s stall%0d node", name, s), out_node, n);
          check($sformatf("%s stall%0d data", name, s), out_data, model(n));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (n == NUM_NODES - 1) begin
        check($sformatf("%s done pulse", name), done, 1);
        check($sformatf("%s idle in_ready", name), in_ready, 1);
        @(negedge clk);
        check($sformatf("%s done low", name), done, 0);
      end else begin
        check($sformatf("%s n%0d done", name, n), done, 0);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < (1<<AW); i++) rom[i] = '0;
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset w_addr", w_addr, 0);
    check("reset out_data", out_data, 0);
    check("reset done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // all ones, bias 2 -> 17 everywhere
    fill_rom(1, 2, 1'b0);
    for (int k = 0; k < NUM_IN; k++) av[k] = 8'sd1;
    run_vector("ones", -1, -1);
    check("ones model n5", model(5), 17);

    // negative sum clamps to zero
    fill_rom(-1, 0, 1'b0);
    for (int k = 0; k < NUM_IN; k++) av[k] = 8'sd10;
    run_vector("neg", -1, -1);

    // two 127*127 terms plus bias fit; a third wraps negative
    fill_rom(127, 127, 1'b0);
    for (int k = 0; k < NUM_IN; k++) av[k] = (k < 2) ? 8'sd127 : 8'sd0;
    check("wrap2 model", model(0), 32385);
    run_vector("wrap2", -1, -1);
    av[2] = 8'sd127;
    check("wrap3 model", model(0), 0);
    run_vector("wrap3", -1, -1);

    // random contents, with a stalled consumer at node 3
    for (int v = 0; v < 3; v++) begin
      fill_rom(0, 0, 1'b1);
      for (int k = 0; k < NUM_IN; k++) av[k] = 8'($urandom);
      run_vector($sformatf("rnd%0d", v), (v == 1) ? 3 : -1, -1);
    end

    // asynchronous reset in the middle of node 7, then a fresh vector
    fill_rom(0, 0, 1'b1);
    for (int k = 0; k < NUM_IN; k++) av[k] = 8'($urandom);
    run_vector("abort", -1, 7);
    for (int k = 0; k < NUM_IN; k++) av[k] = 8'($urandom);
    run_vector("fresh", -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter NUM_IN, default 15, number of 8-bit signed activations per input vector.
REQ-002 Parameter NUM_NODES, default 16, number of output neurons computed on one shared MAC (legal range 1..16).
REQ-003 Parameter AW, default 8, weight-ROM address width; AW SHALL satisfy 2^AW >= NUM_NODES*(NUM_IN+1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low = asserted.
REQ-006 in_valid  input  1  input vector offered.
REQ-007 in_ready  output  1  block can accept a vector (high only in IDLE).
REQ-008 in_data  input  NUM_IN*8  packed signed activations, activation k at bits [8k+7:8k].
REQ-009 w_addr  output  AW  registered weight/bias ROM address.
REQ-010 w_data  input  8  signed ROM data; value for the address driven in cycle c is valid in cycle c+1.
REQ-011 out_valid  output  1  result for out_node is valid.
REQ-012 out_ready  input  1  consumer accepts result when high together with out_valid.
REQ-013 out_node  output  4  index of neuron whose result is on out_data.
REQ-014 out_data  output  16  ReLU'd neuron result.
REQ-015 done  output  1  one-cycle pulse after last neuron's result is accepted.

Function
REQ-016 States SHALL be IDLE, RUN, EMIT; no other reachable states.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, capture in_data into an internal register, set node=0, k=0, acc=0, go to RUN.
REQ-018 in_valid while not in IDLE SHALL be ignored and in_data not recaptured.
REQ-019 ROM layout: weight for (node n, input k) at address n*(NUM_IN+1)+k for k<NUM_IN; bias of node n at address n*(NUM_IN+1)+NUM_IN.
REQ-020 RUN: w_addr SHALL step through the NUM_IN+1 addresses of the current node, one per cycle, in cycles R..R+NUM_IN (R = first RUN cycle).
REQ-021 Data returned for input address k SHALL add sign-extended 16-bit product A[k]*w_data to acc; data for the bias address SHALL add sign-extended w_data.
REQ-022 Accumulation SHALL be 16-bit two's-complement with silent wrap; no saturation.
REQ-023 RUN lasts NUM_IN+2 cycles (addresses plus one drain cycle for the bias data), then EMIT.
REQ-024 Latency: accept in cycle T -> out_valid for node 0 first high in cycle T+NUM_IN+3 (T+18 for defaults).
REQ-025 EMIT: out_valid=1, out_node=node, out_data = acc if acc[15]==0, else 16'd0.
REQ-026 out_valid, out_node, out_data SHALL hold stable while out_valid&~out_ready.
REQ-027 On out_valid&out_ready: if node<NUM_NODES-1, node+=1, k=0, acc=0, go to RUN next cycle; else go to IDLE and pulse done for exactly that next cycle.
REQ-028 Subsequent neuron latency: handshake in cycle H -> next out_valid in cycle H+NUM_IN+3.
REQ-029 out_valid SHALL be 0 in IDLE and RUN; w_addr SHALL hold its last value outside RUN.
REQ-030 A new vector SHALL be accepted no earlier than the cycle after done pulses (in_ready high with done).

Reset
REQ-031 reset low SHALL immediately, without clk, force state=IDLE, node=0, k=0, acc=0, w_addr=0, out_valid=0, out_node=0, out_data=0, done=0, captured activations=0.
REQ-032 in_ready SHALL be 0 while reset is low and 1 from the first cycle after release.
REQ-033 Reset asserted mid-RUN or mid-EMIT SHALL abort the vector; no out_valid or done for it after release.

Verification
REQ-034 All A=1, all weights=1, all biases=2, out_ready=1 -> 16 results, each out_data=17, out_node 0..15 in order, first at T+18, spacing 18 cycles, single done pulse.
REQ-035 A=10, weights=-1, bias=0 -> acc=-150 -> out_data=0 for every node.
REQ-036 A[0..2]=127, rest 0, weights 127, bias 127: only A[0..1] nonzero -> out_data=32385; all three nonzero -> 16-bit wrap to negative -> out_data=0.
REQ-037 out_ready held low 5 cycles at node 3 -> out_valid/out_node=3/out_data stable throughout; in_valid pulses during that time ignored; node 4 follows H+18.
REQ-038 reset pulled low asynchronously mid-RUN of node 7 -> all outputs 0 before next edge; after release in_ready=1, no stray out_valid/done; fresh vector then yields correct results from node 0.
